// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, ALU-op encodings and control-word layouts for the control pipeline.
package cpu_ctrl_pkg;

    // Opcode map
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    // ALU operation classes
    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluBranch = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;
    localparam logic [1:0] AluPassB  = 2'b11;

    // Control word, MSB first: {alusrc,memtoreg,regwrite,memread,memwrite,branch,jump,aluop}
    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic       jump;
        logic [1:0] aluop;
    } ctrl_t;

    // EX/MEM register contents
    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic [4:0] rd;
    } mem_stage_t;

    // MEM/WB register contents
    typedef struct packed {
        logic       memtoreg;
        logic       regwrite;
        logic [4:0] rd;
    } wb_stage_t;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word, legality and source-register usage.
module ctrl_decode
    import cpu_ctrl_pkg::*;
#(
    parameter bit SUPPORT_JUMP = 1'b0
) (
    input  logic       valid_i,
    input  logic [6:0] opcode_i,
    output ctrl_t      ctrl_o,
    output logic       known_o,
    output logic       rs1_used_o,
    output logic       rs2_used_o
);

    // Opcode table; unknown or invalid instructions yield the all-zero word
    always_comb begin
        ctrl_o  = '0;
        known_o = 1'b1;
        case (opcode_i)
            OpcOpImm: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = AluFunct;
            end
            OpcOp: begin
                ctrl_o.regwrite = 1'b1;
                ctrl_o.aluop    = AluFunct;
            end
            OpcLoad: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
                ctrl_o.memread  = 1'b1;
                ctrl_o.aluop    = AluAdd;
            end
            OpcStore: begin
                ctrl_o.alusrc   = 1'b1;
                ctrl_o.memwrite = 1'b1;
                ctrl_o.aluop    = AluAdd;
            end
            OpcBranch: begin
                ctrl_o.branch = 1'b1;
                ctrl_o.aluop  = AluBranch;
            end
            OpcJal, OpcJalr: begin
                if (SUPPORT_JUMP) begin
                    ctrl_o.alusrc   = (opcode_i == OpcJalr);
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.jump     = 1'b1;
                    ctrl_o.aluop    = AluAdd;
                end else begin
                    known_o = 1'b0;
                end
            end
            OpcLui, OpcAuipc: begin
                if (SUPPORT_JUMP) begin
                    ctrl_o.alusrc   = 1'b1;
                    ctrl_o.regwrite = 1'b1;
                    ctrl_o.aluop    = (opcode_i == OpcLui) ? AluPassB : AluAdd;
                end else begin
                    known_o = 1'b0;
                end
            end
            default: known_o = 1'b0;
        endcase
        if (!valid_i) begin
            ctrl_o = '0;
        end
    end

    // Source usage is a property of the opcode format, independent of SUPPORT_JUMP
    always_comb begin
        rs1_used_o = !(opcode_i inside {OpcLui, OpcAuipc, OpcJal});
        rs2_used_o = opcode_i inside {OpcOp, OpcStore, OpcBranch};
    end

endmodule

// File: rtl/control_pipeline.sv
// Three-stage control pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// flush handling and saturating stall/flush event counters.
module control_pipeline
    import cpu_ctrl_pkg::*;
#(
    parameter bit          SUPPORT_JUMP = 1'b0,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             id_valid,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic             flush,
    output logic             stall,
    output logic             illegal,
    output logic             ex_alusrc,
    output logic [1:0]       ex_aluop,
    output logic             ex_branch,
    output logic             ex_jump,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             wb_memtoreg,
    output logic             wb_regwrite,
    output logic [4:0]       wb_rd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_t            id_ctrl;
    logic             id_known;
    logic             id_rs1_used;
    logic             id_rs2_used;
    logic             load_use;

    ctrl_t            idex_ctrl_q, idex_ctrl_d;
    logic [4:0]       idex_rd_q, idex_rd_d;
    mem_stage_t       exmem_q, exmem_d;
    wb_stage_t        memwb_q, memwb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    ctrl_decode #(
        .SUPPORT_JUMP(SUPPORT_JUMP)
    ) u_decode (
        .valid_i   (id_valid),
        .opcode_i  (id_opcode),
        .ctrl_o    (id_ctrl),
        .known_o   (id_known),
        .rs1_used_o(id_rs1_used),
        .rs2_used_o(id_rs2_used)
    );

    // Hazard detection; reset and flush both mask stall and illegal
    always_comb begin
        load_use = idex_ctrl_q.memread && (idex_rd_q != 5'd0) &&
                   ((id_rs1_used && (id_rs1 == idex_rd_q)) ||
                    (id_rs2_used && (id_rs2 == idex_rd_q)));
        stall    = rstn && !flush && id_valid && load_use;
        illegal  = rstn && !flush && id_valid && !id_known;
    end

    // Next-state: bubble injection into ID/EX, stage advance, saturating counters
    always_comb begin
        idex_ctrl_d = id_ctrl;
        idex_rd_d   = id_valid ? id_rd : 5'd0;
        if (stall || flush) begin
            idex_ctrl_d = '0;
            idex_rd_d   = 5'd0;
        end

        exmem_d = '{memtoreg: idex_ctrl_q.memtoreg,
                    regwrite: idex_ctrl_q.regwrite,
                    memread:  idex_ctrl_q.memread,
                    memwrite: idex_ctrl_q.memwrite,
                    rd:       idex_rd_q};
        memwb_d = '{memtoreg: exmem_q.memtoreg,
                    regwrite: exmem_q.regwrite,
                    rd:       exmem_q.rd};

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (flush && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            idex_ctrl_q <= '0;
            idex_rd_q   <= '0;
            exmem_q     <= '0;
            memwb_q     <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_ctrl_q <= idex_ctrl_d;
            idex_rd_q   <= idex_rd_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Registered outputs
    always_comb begin
        ex_alusrc    = idex_ctrl_q.alusrc;
        ex_aluop     = idex_ctrl_q.aluop;
        ex_branch    = idex_ctrl_q.branch;
        ex_jump      = idex_ctrl_q.jump;
        mem_memread  = exmem_q.memread;
        mem_memwrite = exmem_q.memwrite;
        wb_memtoreg  = memwb_q.memtoreg;
        wb_regwrite  = memwb_q.regwrite;
        wb_rd        = memwb_q.rd;
        stall_cnt    = stall_cnt_q;
        flush_cnt    = flush_cnt_q;
    end

endmodule

// File: tb/tb_control_pipeline.sv
// Randomized + directed bench for control_pipeline. Two instances share stimulus:
// dut0 uses defaults, dut1 has SUPPORT_JUMP=1 and CNT_W=2.
module tb_control_pipeline;

    logic       clk = 1'b0;
    logic       rstn;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       flush;

    logic        stall_0, illegal_0, ex_alusrc_0, ex_branch_0, ex_jump_0;
    logic [1:0]  ex_aluop_0;
    logic        mem_memread_0, mem_memwrite_0, wb_memtoreg_0, wb_regwrite_0;
    logic [4:0]  wb_rd_0;
    logic [15:0] stall_cnt_0, flush_cnt_0;

    logic        stall_1, illegal_1, ex_alusrc_1, ex_branch_1, ex_jump_1;
    logic [1:0]  ex_aluop_1;
    logic        mem_memread_1, mem_memwrite_1, wb_memtoreg_1, wb_regwrite_1;
    logic [4:0]  wb_rd_1;
    logic [1:0]  stall_cnt_1, flush_cnt_1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    control_pipeline u_dut0 (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall_0), .illegal(illegal_0), .ex_alusrc(ex_alusrc_0),
        .ex_aluop(ex_aluop_0), .ex_branch(ex_branch_0), .ex_jump(ex_jump_0),
        .mem_memread(mem_memread_0), .mem_memwrite(mem_memwrite_0),
        .wb_memtoreg(wb_memtoreg_0), .wb_regwrite(wb_regwrite_0), .wb_rd(wb_rd_0),
        .stall_cnt(stall_cnt_0), .flush_cnt(flush_cnt_0)
    );

    control_pipeline #(
        .SUPPORT_JUMP(1'b1),
        .CNT_W       (2)
    ) u_dut1 (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .flush(flush),
        .stall(stall_1), .illegal(illegal_1), .ex_alusrc(ex_alusrc_1),
        .ex_aluop(ex_aluop_1), .ex_branch(ex_branch_1), .ex_jump(ex_jump_1),
        .mem_memread(mem_memread_1), .mem_memwrite(mem_memwrite_1),
        .wb_memtoreg(wb_memtoreg_1), .wb_regwrite(wb_regwrite_1), .wb_rd(wb_rd_1),
        .stall_cnt(stall_cnt_1), .flush_cnt(flush_cnt_1)
    );

    // Reference model: each stage entry is {control word, rd}
    // cw bits: 8 alusrc, 7 memtoreg, 6 regwrite, 5 memread, 4 memwrite, 3 branch, 2 jump, 1:0 aluop
    typedef struct packed {
        logic [8:0] cw;
        logic [4:0] rd;
    } ent_t;

    ent_t m_ex[2], m_mem[2], m_wb[2];
    int   m_scnt[2], m_fcnt[2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // {known, cw} straight from the opcode table
    function automatic logic [9:0] ref_decode(input bit sj, input logic [6:0] op);
        case (op)
            7'b0010011: return {1'b1, 9'b1_0_1_0_0_0_0_10};
            7'b0110011: return {1'b1, 9'b0_0_1_0_0_0_0_10};
            7'b0000011: return {1'b1, 9'b1_1_1_1_0_0_0_00};
            7'b0100011: return {1'b1, 9'b1_0_0_0_1_0_0_00};
            7'b1100011: return {1'b1, 9'b0_0_0_0_0_1_0_01};
            7'b1101111: return sj ? {1'b1, 9'b0_0_1_0_0_0_1_00} : 10'd0;
            7'b1100111: return sj ? {1'b1, 9'b1_0_1_0_0_0_1_00} : 10'd0;
            7'b0110111: return sj ? {1'b1, 9'b1_0_1_0_0_0_0_11} : 10'd0;
            7'b0010111: return sj ? {1'b1, 9'b1_0_1_0_0_0_0_00} : 10'd0;
            default:    return 10'd0;
        endcase
    endfunction

    function automatic bit exp_stall(input int c);
        bit u1, u2, hit;
        u1  = !(id_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
        u2  = id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
        hit = (u1 && id_rs1 == m_ex[c].rd) || (u2 && id_rs2 == m_ex[c].rd);
        return rstn && !flush && id_valid && m_ex[c].cw[5] && (m_ex[c].rd != 5'd0) && hit;
    endfunction

    function automatic bit exp_illegal(input int c);
        logic [9:0] d;
        d = ref_decode(c == 1, id_opcode);
        return rstn && !flush && id_valid && !d[9];
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_ex[c] = '0; m_mem[c] = '0; m_wb[c] = '0; m_scnt[c] = 0; m_fcnt[c] = 0;
        end
    endtask

    // Advance the model by one rising edge using the inputs held in that cycle
    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            bit         s;
            logic [9:0] d;
            int         cmax;
            s    = exp_stall(c);
            d    = ref_decode(c == 1, id_opcode);
            cmax = (c == 0) ? 65535 : 3;
            if (!rstn) begin
                m_ex[c] = '0; m_mem[c] = '0; m_wb[c] = '0; m_scnt[c] = 0; m_fcnt[c] = 0;
            end else begin
                if (s && m_scnt[c] < cmax) m_scnt[c]++;
                if (flush && m_fcnt[c] < cmax) m_fcnt[c]++;
                m_wb[c]  = m_mem[c];
                m_mem[c] = m_ex[c];
                if (s || flush || !id_valid) m_ex[c] = '0;
                else m_ex[c] = '{cw: d[8:0], rd: id_rd};
            end
        end
    endtask

    task automatic check_dut(input int c);
        logic        g_st, g_il;
        logic [4:0]  g_ex, e_ex;
        logic [1:0]  g_mem;
        logic [6:0]  g_wb;
        logic [31:0] g_sc, g_fc;
        if (c == 0) begin
            g_st = stall_0; g_il = illegal_0;
            g_ex = {ex_alusrc_0, ex_aluop_0, ex_branch_0, ex_jump_0};
            g_mem = {mem_memread_0, mem_memwrite_0};
            g_wb = {wb_memtoreg_0, wb_regwrite_0, wb_rd_0};
            g_sc = 32'(stall_cnt_0); g_fc = 32'(flush_cnt_0);
        end else begin
            g_st = stall_1; g_il = illegal_1;
            g_ex = {ex_alusrc_1, ex_aluop_1, ex_branch_1, ex_jump_1};
            g_mem = {mem_memread_1, mem_memwrite_1};
            g_wb = {wb_memtoreg_1, wb_regwrite_1, wb_rd_1};
            g_sc = 32'(stall_cnt_1); g_fc = 32'(flush_cnt_1);
        end
        e_ex = {m_ex[c].cw[8], m_ex[c].cw[1:0], m_ex[c].cw[3], m_ex[c].cw[2]};
        check_val($sformatf("d%0d.stall", c), 32'(g_st), 32'(exp_stall(c)));
        check_val($sformatf("d%0d.illegal", c), 32'(g_il), 32'(exp_illegal(c)));
        check_val($sformatf("d%0d.ex", c), 32'(g_ex), 32'(e_ex));
        check_val($sformatf("d%0d.mem", c), 32'(g_mem), 32'({m_mem[c].cw[5], m_mem[c].cw[4]}));
        check_val($sformatf("d%0d.wb", c), 32'(g_wb),
                  32'({m_wb[c].cw[7], m_wb[c].cw[6], m_wb[c].rd}));
        check_val($sformatf("d%0d.stall_cnt", c), g_sc, 32'(m_scnt[c]));
        check_val($sformatf("d%0d.flush_cnt", c), g_fc, 32'(m_fcnt[c]));
    endtask

    // One clock: compare mid-cycle, step the model at the edge, then release inputs
    task automatic cycle();
        @(negedge clk);
        check_dut(0);
        check_dut(1);
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic fl);
        id_valid = v; id_opcode = op; id_rs1 = r1; id_rs2 = r2; id_rd = rd; flush = fl;
    endtask

    localparam logic [6:0] OpTab [9] = '{7'b0010011, 7'b0110011, 7'b0000011, 7'b0100011,
                                         7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                         7'b0010111};

    initial begin
        int s0, f0;
        // Initial reset with hazard-like inputs present
        rstn = 1'b0;
        drive(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd3, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        model_reset();
        drive(1'b1, 7'b1111111, 5'd3, 5'd3, 5'd3, 1'b0);
        #1;
        check_val("rst.stall_masked", 32'(stall_0), 32'd0);
        check_val("rst.illegal_masked", 32'(illegal_0), 32'd0);
        cycle();
        rstn = 1'b1;

        // Load-use on rs1: one stall cycle, bubble in EX, then the OP
        drive(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd5, 1'b0); cycle();
        drive(1'b1, 7'b0110011, 5'd5, 5'd2, 5'd6, 1'b0); #1;
        check_val("lu.stall_hi", 32'(stall_0), 32'd1);
        cycle();
        #1;
        check_val("lu.stall_lo", 32'(stall_0), 32'd0);
        check_val("lu.ex_bubble", 32'({ex_alusrc_0, ex_aluop_0}), 32'd0);
        check_val("lu.stall_cnt", 32'(stall_cnt_0), 32'd1);
        cycle();
        drive(1'b0, 7'b0, 5'd0, 5'd0, 5'd0, 1'b0); #1;
        check_val("lu.op_in_ex", 32'(ex_aluop_0), 32'd2);
        cycle();

        // Load to x0 never stalls
        drive(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd0, 1'b0); cycle();
        drive(1'b1, 7'b0110011, 5'd0, 5'd0, 5'd6, 1'b0); #1;
        check_val("x0.no_stall", 32'(stall_0), 32'd0);
        cycle();

        // LUI does not read rs1
        drive(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd7, 1'b0); cycle();
        drive(1'b1, 7'b0110111, 5'd7, 5'd1, 5'd8, 1'b0); #1;
        check_val("lui.no_stall", 32'(stall_1), 32'd0);
        cycle();

        // Flush beats a pending load-use hazard
        drive(1'b1, 7'b0100011, 5'd1, 5'd2, 5'd4, 1'b0); cycle();
        drive(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd9, 1'b0); cycle();
        drive(1'b1, 7'b0110011, 5'd9, 5'd9, 5'd10, 1'b1); #1;
        check_val("fl.stall_forced0", 32'(stall_0), 32'd0);
        s0 = int'(stall_cnt_0); f0 = int'(flush_cnt_0);
        cycle();
        #1;
        check_val("fl.ex_bubble", 32'({ex_alusrc_0, ex_aluop_0}), 32'd0);
        check_val("fl.flush_cnt", 32'(flush_cnt_0), 32'(f0 + 1));
        check_val("fl.stall_cnt", 32'(stall_cnt_0), 32'(s0));

        // OP-IMM latency through the stages, then an illegal opcode
        drive(1'b1, 7'b0010011, 5'd1, 5'd2, 5'd3, 1'b0); cycle();
        drive(1'b0, 7'b0, 5'd0, 5'd0, 5'd0, 1'b0); #1;
        check_val("lat.ex_alusrc", 32'(ex_alusrc_0), 32'd1);
        cycle(); cycle(); #1;
        check_val("lat.wb", 32'({wb_regwrite_0, wb_rd_0}), 32'({1'b1, 5'd3}));
        drive(1'b1, 7'b1111111, 5'd1, 5'd2, 5'd3, 1'b0); #1;
        check_val("ill.flag", 32'(illegal_0), 32'd1);
        cycle();
        drive(1'b0, 7'b0, 5'd0, 5'd0, 5'd0, 1'b0); #1;
        check_val("ill.ex_zero", 32'({ex_alusrc_0, ex_aluop_0, ex_branch_0, ex_jump_0}), 32'd0);
        cycle();

        // Saturation on the 2-bit instance, then reset clears everything
        rstn = 1'b0; cycle(); rstn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd4, 1'b0); cycle();
            drive(1'b1, 7'b0110011, 5'd4, 5'd1, 5'd5, 1'b0); cycle();
        end
        #1;
        check_val("sat.cnt2", 32'(stall_cnt_1), 32'd3);
        check_val("sat.cnt16", 32'(stall_cnt_0), 32'd5);
        rstn = 1'b0;
        drive(1'b1, 7'b0000011, 5'd1, 5'd2, 5'd4, 1'b0); cycle();
        drive(1'b1, 7'b0110011, 5'd4, 5'd4, 5'd5, 1'b0); #1;
        check_val("sat.rst_all0",
                  32'({stall_1, illegal_1, ex_alusrc_1, ex_aluop_1, ex_branch_1, ex_jump_1,
                       mem_memread_1, mem_memwrite_1, wb_memtoreg_1, wb_regwrite_1, wb_rd_1,
                       stall_cnt_1, flush_cnt_1}), 32'd0);
        cycle();
        rstn = 1'b1;

        // Randomized traffic with small register indices to provoke hazards
        for (int i = 0; i < 1500; i++) begin
            int sel;
            sel       = int'($urandom_range(0, 9));
            id_opcode = (sel < 9) ? OpTab[sel] : 7'($urandom);
            id_valid  = ($urandom_range(0, 4) != 0);
            id_rs1    = 5'($urandom_range(0, 7));
            id_rs2    = 5'($urandom_range(0, 7));
            id_rd     = 5'($urandom_range(0, 7));
            flush     = ($urandom_range(0, 7) == 0);
            rstn      = ($urandom_range(0, 63) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/control_pipeline.md
CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 Parameter SUPPORT_JUMP, default 0, SHALL enable decode of JAL/JALR/LUI/AUIPC when 1.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the stall and flush event counters.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rstn  in  1  reset, synchronous, active-low.
REQ-005 id_valid  in  1  the ID stage holds a real instruction.
REQ-006 id_opcode  in  7  opcode of the ID instruction.
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  register indices of the ID instruction.
REQ-008 flush  in  1  branch/jump taken, resolved in EX; kills the ID instruction.
REQ-009 stall  out  1  hold PC and IF/ID; high on a load-use hazard.
REQ-010 illegal  out  1  the ID instruction has a valid, undecodable opcode.
REQ-011 ex_alusrc, ex_aluop[1:0], ex_branch, ex_jump  out  control fields of the EX stage.
REQ-012 mem_memread, mem_memwrite  out  1 each  control fields of the MEM stage.
REQ-013 wb_memtoreg, wb_regwrite  out  1 each; wb_rd  out  5  WB stage fields.
REQ-014 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.

Function
REQ-015 Decode, as {alusrc,memtoreg,regwrite,memread,memwrite,branch,jump,aluop}: 0010011 -> 1,0,1,0,0,0,0,10; 0110011 -> 0,0,1,0,0,0,0,10; 0000011 -> 1,1,1,1,0,0,0,00; 0100011 -> 1,0,0,0,1,0,0,00; 1100011 -> 0,0,0,0,0,1,0,01.
REQ-016 With SUPPORT_JUMP=1: 1101111 and 1100111 -> regwrite=1, jump=1, aluop=00, with alusrc=1 for 1100111 only; 0110111 -> alusrc=1, regwrite=1, aluop=11; 0010111 -> alusrc=1, regwrite=1, aluop=00.
REQ-017 Any other opcode, or id_valid=0, SHALL decode to the all-zero word; illegal = id_valid & unknown opcode & ~flush.
REQ-018 rs1 SHALL count as used for every opcode except 0110111, 0010111 and 1101111; rs2 SHALL count as used only for 0110011, 0100011 and 1100011.
REQ-019 The pipeline SHALL be three registered stages, ID/EX -> EX/MEM -> MEM/WB, and rd SHALL travel with each stage.
REQ-020 Latency: decoded ID fields SHALL appear on ex_* 1 cycle, mem_* 2 cycles and wb_* 3 cycles after the ID cycle.
REQ-021 stall SHALL be 1 when id_valid=1, the EX-stage memread=1, EX rd != 0, and EX rd equals a used rs1 or rs2; stall is combinational from registered state and inputs.
REQ-022 While stall=1, ID/EX SHALL load the zero bubble, and EX/MEM and MEM/WB SHALL advance normally.
REQ-023 When flush=1, ID/EX SHALL load the bubble, and stall and illegal SHALL be forced to 0; flush SHALL take priority over stall.
REQ-024 A bubble SHALL never raise regwrite, memread or memwrite downstream.
REQ-025 stall_cnt SHALL increment on every stall=1 cycle and flush_cnt on every flush=1 cycle; both SHALL saturate at 2^CNT_W-1 and never wrap.

Reset
REQ-026 rstn=0 at a rising edge SHALL clear all stage registers and both counters; every registered output reads 0 in the next cycle.
REQ-027 During reset, stall and illegal SHALL be 0 regardless of inputs.
REQ-028 Reset mid-stall SHALL discard the bubble and any in-flight loads.

Structure
REQ-029 The opcode constants, aluop encodings and control-word field positions SHALL live in a shared package, cpu_ctrl_pkg.
REQ-030 Decode SHALL be the one sub-module ctrl_decode (combinational); hazard logic, stage registers and counters SHALL stay in control_pipeline.

Verification
REQ-031 LOAD rd=5, then OP rs1=5 -> stall=1 for exactly 1 cycle, EX holds the bubble, the OP reaches EX one cycle later, stall_cnt=1.
REQ-032 LOAD rd=0, then OP rs1=0 -> stall=0.
REQ-033 LOAD rd=7, then LUI with rs1 field=7 (SUPPORT_JUMP=1) -> stall=0.
REQ-034 STORE, then flush=1 while a load-use hazard is present -> stall=0, ID/EX bubble, flush_cnt increments, stall_cnt unchanged.
REQ-035 OP-IMM rd=3 issued at cycle t -> ex_alusrc=1 at t+1, wb_regwrite=1 with wb_rd=3 at t+3; opcode 1111111 with id_valid=1 -> illegal=1 and all control fields 0.
REQ-036 CNT_W=2 with 5 consecutive stall cycles -> stall_cnt=3; then rstn=0 for one edge -> all outputs 0.
